// File: rtl/uart_cmd_pkg.sv
// rtl/uart_cmd_pkg.sv - shared states and command codes for the UART command sequencer
package uart_cmd_pkg;

   localparam logic [1:0] IDLE       = 2'd0;
   localparam logic [1:0] GET_ROW    = 2'd1;
   localparam logic [1:0] GET_DATA   = 2'd2;
   localparam logic [1:0] GET_BRIGHT = 2'd3;

   localparam logic [7:0] CMD_LINE   = 8'h4C;
   localparam logic [7:0] CMD_BRIGHT = 8'h42;

   function automatic logic is_command(input logic [7:0] b);
      return (b == CMD_LINE) || (b == CMD_BRIGHT);
   endfunction

endpackage

// File: rtl/uart_cmd_timeout.sv
// rtl/uart_cmd_timeout.sv - inter-byte watchdog for frame-based receivers
// Counts enabled cycles since the last clear; expired pulses once at TIMEOUT_CYCLES-1.
module uart_cmd_timeout #(
   parameter int TIMEOUT_CYCLES = 2000
) (
   input  logic clk_in,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   logic [15:0] count;

   // A clear in the same cycle overrides expiry so a late byte still gets processed.
   assign expired = enable & ~clear & (count == 16'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clear || !enable || expired) begin
         count <= '0;
      end else begin
         count <= count + 16'd1;
      end
   end

endmodule

// File: rtl/uart_cmd_sequencer.sv
// rtl/uart_cmd_sequencer.sv - decodes UART byte frames into row RAM writes and brightness updates
// Frames: 'L' row b0..b(N-1) writes one row; 'B' v sets brightness; bad bytes and stalls abort.
module uart_cmd_sequencer
   import uart_cmd_pkg::*;
#(
   parameter int   ROW_BYTES      = 32,
   parameter int   ROW_WIDTH      = 5,
   parameter int   TIMEOUT_CYCLES = 2000,
   parameter logic [7:0] BRIGHT_RESET = 8'hFF,
   localparam int  ADDR_WIDTH     = ROW_WIDTH + $clog2(ROW_BYTES)
) (
   input  logic                  clk_in,
   input  logic                  reset,
   input  logic [7:0]            rx_data,
   input  logic                  rx_running,
   input  logic                  rx_invalid,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [7:0]            ram_data,
   output logic                  ram_we,
   output logic [7:0]            brightness,
   output logic                  frame_done,
   output logic                  frame_error,
   output logic                  busy
);

   localparam int COL_WIDTH = $clog2(ROW_BYTES);

   logic [1:0]            state, state_nxt;
   logic                  run_q;
   logic                  strobe;
   logic                  expired;
   logic [ROW_WIDTH-1:0]  row, row_nxt;
   logic [COL_WIDTH-1:0]  col, col_nxt;
   logic [ADDR_WIDTH-1:0] addr_nxt;
   logic [7:0]            data_nxt;
   logic [7:0]            bright_nxt;
   logic                  we_nxt, done_nxt, err_nxt;

   // A byte is complete on the falling edge of rx_running.
   assign strobe = run_q & ~rx_running;

   uart_cmd_timeout #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk_in (clk_in),
      .reset  (reset),
      .clear  (strobe),
      .enable (state != IDLE),
      .expired(expired)
   );

   always_comb begin
      state_nxt  = state;
      row_nxt    = row;
      col_nxt    = col;
      addr_nxt   = ram_addr;
      data_nxt   = ram_data;
      bright_nxt = brightness;
      we_nxt     = 1'b0;
      done_nxt   = 1'b0;
      err_nxt    = 1'b0;

      if (strobe && rx_invalid) begin
         err_nxt   = 1'b1;
         state_nxt = IDLE;
      end else if (strobe) begin
         case (state)
            IDLE: begin
               if (!is_command(rx_data)) begin
                  err_nxt = 1'b1;
               end else if (rx_data == CMD_LINE) begin
                  state_nxt = GET_ROW;
               end else begin
                  state_nxt = GET_BRIGHT;
               end
            end
            GET_ROW: begin
               row_nxt   = rx_data[ROW_WIDTH-1:0];
               col_nxt   = '0;
               state_nxt = GET_DATA;
            end
            GET_DATA: begin
               we_nxt   = 1'b1;
               addr_nxt = {row, col};
               data_nxt = rx_data;
               col_nxt  = col + 1'b1;
               // The last column ends the frame, so col never carries into the row bits.
               if (col == COL_WIDTH'(ROW_BYTES - 1)) begin
                  done_nxt  = 1'b1;
                  state_nxt = IDLE;
               end
            end
            default: begin
               bright_nxt = rx_data;
               done_nxt   = 1'b1;
               state_nxt  = IDLE;
            end
         endcase
      end else if (expired) begin
         err_nxt   = 1'b1;
         state_nxt = IDLE;
      end
   end

   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         run_q       <= 1'b0;
         row         <= '0;
         col         <= '0;
         ram_addr    <= '0;
         ram_data    <= '0;
         ram_we      <= 1'b0;
         brightness  <= BRIGHT_RESET;
         frame_done  <= 1'b0;
         frame_error <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state       <= state_nxt;
         run_q       <= rx_running;
         row         <= row_nxt;
         col         <= col_nxt;
         ram_addr    <= addr_nxt;
         ram_data    <= data_nxt;
         ram_we      <= we_nxt;
         brightness  <= bright_nxt;
         frame_done  <= done_nxt;
         frame_error <= err_nxt;
         busy        <= (state_nxt != IDLE);
      end
   end

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// tb/tb_uart_cmd_sequencer.sv - randomized self-checking bench for uart_cmd_sequencer
module tb_uart_cmd_sequencer;

   localparam int ROW_BYTES = 32;
   localparam int ROW_WIDTH = 5;
   localparam int TO_CYC    = 2000;
   localparam int AW        = 10;

   logic          tb_clk_baudrate = 1'b0;
   logic          reset = 1'b1;
   logic [7:0]    rx_data = 8'h00;
   logic          rx_running = 1'b0;
   logic          rx_invalid = 1'b0;
   logic [AW-1:0] ram_addr;
   logic [7:0]    ram_data;
   logic          ram_we;
   logic [7:0]    brightness;
   logic          frame_done;
   logic          frame_error;
   logic          busy;

   int total = 0;
   int bad   = 0;

   uart_cmd_sequencer #(
      .ROW_BYTES(ROW_BYTES),
      .ROW_WIDTH(ROW_WIDTH),
      .TIMEOUT_CYCLES(TO_CYC),
      .BRIGHT_RESET(8'hFF)
   ) dut (
      .clk_in     (tb_clk_baudrate),
      .reset      (reset),
      .rx_data    (rx_data),
      .rx_running (rx_running),
      .rx_invalid (rx_invalid),
      .ram_addr   (ram_addr),
      .ram_data   (ram_data),
      .ram_we     (ram_we),
      .brightness (brightness),
      .frame_done (frame_done),
      .frame_error(frame_error),
      .busy       (busy)
   );

   always #5 tb_clk_baudrate = ~tb_clk_baudrate;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: tracks the frame as "bytes received since the command".
   bit       m_prev, in_frame;
   int       got, since, m_row;
   bit [7:0] cmd;
   bit       e_we, e_done, e_err, e_busy;
   int       e_addr, e_data, e_bright;

   always @(posedge tb_clk_baudrate or posedge reset) begin
      if (reset) begin
         m_prev = 0; in_frame = 0; got = 0; since = 0; m_row = 0; cmd = 0;
         e_we = 0; e_done = 0; e_err = 0; e_busy = 0;
         e_addr = 0; e_data = 0; e_bright = 8'hFF;
      end else begin
         bit st;
         st = m_prev && !rx_running;
         m_prev = rx_running;
         e_we = 0; e_done = 0; e_err = 0;
         if (st) begin
            since = 0;
            if (rx_invalid) begin
               e_err = 1; in_frame = 0;
            end else if (!in_frame) begin
               if (rx_data == 8'h4C || rx_data == 8'h42) begin
                  in_frame = 1; cmd = rx_data; got = 0;
               end else begin
                  e_err = 1;
               end
            end else begin
               got++;
               if (cmd == 8'h42) begin
                  e_bright = rx_data; e_done = 1; in_frame = 0;
               end else if (got == 1) begin
                  m_row = rx_data % (1 << ROW_WIDTH);
               end else begin
                  e_we = 1;
                  e_addr = m_row * ROW_BYTES + (got - 2);
                  e_data = rx_data;
                  if (got - 2 == ROW_BYTES - 1) begin
                     e_done = 1; in_frame = 0;
                  end
               end
            end
         end else if (in_frame) begin
            since++;
            if (since == TO_CYC) begin
               e_err = 1; in_frame = 0;
            end
         end
         e_busy = in_frame;
      end
   end

   // Observed-event statistics for the hand-computed checks.
   int n_we, n_done, n_err, first_addr, last_addr, done_with_we;

   task automatic clr_stats();
      n_we = 0; n_done = 0; n_err = 0; first_addr = -1; last_addr = -1; done_with_we = 0;
   endtask

   always @(negedge tb_clk_baudrate) begin
      if (!reset) begin
         chk("ram_we", int'(ram_we), int'(e_we));
         chk("frame_done", int'(frame_done), int'(e_done));
         chk("frame_error", int'(frame_error), int'(e_err));
         chk("busy", int'(busy), int'(e_busy));
         chk("brightness", int'(brightness), e_bright);
         chk("ram_addr", int'(ram_addr), e_addr);
         chk("ram_data", int'(ram_data), e_data);
         if (ram_we) begin
            if (n_we == 0) first_addr = int'(ram_addr);
            last_addr = int'(ram_addr);
            n_we++;
         end
         if (frame_done) begin
            n_done++;
            done_with_we = int'(ram_we);
         end
         if (frame_error) n_err++;
      end
   end

   task automatic send_byte(input logic [7:0] b, input bit inv);
      @(negedge tb_clk_baudrate);
      rx_running = 1'b1;
      rx_data = 8'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge tb_clk_baudrate);
      rx_data = b;
      @(negedge tb_clk_baudrate);
      rx_running = 1'b0;
      rx_invalid = inv;
      @(negedge tb_clk_baudrate);
      rx_invalid = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge tb_clk_baudrate);
   endtask

   task automatic settle(input int n);
      repeat (n) @(negedge tb_clk_baudrate);
   endtask

   initial begin
      clr_stats();
      settle(3);
      chk("rst_busy", int'(busy), 0);
      chk("rst_bright", int'(brightness), 8'hFF);
      chk("rst_addr", int'(ram_addr), 0);
      chk("rst_we", int'(ram_we), 0);
      reset = 1'b0;
      settle(2);

      // Brightness frame
      clr_stats();
      send_byte(8'h42, 0); send_byte(8'h3C, 0); settle(2);
      chk("b_value", int'(brightness), 8'h3C);
      chk("b_done_cnt", n_done, 1);
      chk("b_busy", int'(busy), 0);

      // Full row 3
      clr_stats();
      send_byte(8'h4C, 0); send_byte(8'h03, 0);
      for (int i = 0; i < ROW_BYTES; i++) send_byte(8'(i), 0);
      settle(2);
      chk("row3_we_cnt", n_we, 32);
      chk("row3_first", first_addr, 10'h060);
      chk("row3_last", last_addr, 10'h07F);
      chk("row3_done_we", done_with_we, 1);
      chk("row3_done_cnt", n_done, 1);

      // Row index wraps
      clr_stats();
      send_byte(8'h4C, 0); send_byte(8'hE5, 0);
      for (int i = 0; i < ROW_BYTES; i++) send_byte(8'($urandom), 0);
      settle(2);
      chk("wrap_first", first_addr, 10'h0A0);
      chk("wrap_last", last_addr, 10'h0BF);

      // Stalled frame times out
      clr_stats();
      send_byte(8'h4C, 0); send_byte(8'h01, 0);
      for (int i = 0; i < 3; i++) send_byte(8'($urandom), 0);
      settle(TO_CYC + 20);
      chk("to_we_cnt", n_we, 3);
      chk("to_first", first_addr, 10'h020);
      chk("to_last", last_addr, 10'h022);
      chk("to_err_cnt", n_err, 1);
      chk("to_done_cnt", n_done, 0);
      chk("to_busy", int'(busy), 0);

      // Framing error, then unknown command
      clr_stats();
      send_byte(8'h4C, 0); send_byte(8'h00, 0); send_byte(8'h55, 1); settle(2);
      chk("inv_we_cnt", n_we, 0);
      chk("inv_err_cnt", n_err, 1);
      send_byte(8'h7A, 0); settle(2);
      chk("junk_err_cnt", n_err, 2);
      chk("junk_busy", int'(busy), 0);

      // Reset in the middle of a row
      clr_stats();
      send_byte(8'h4C, 0); send_byte(8'h02, 0);
      for (int i = 0; i < 10; i++) send_byte(8'($urandom), 0);
      chk("mid_we_cnt", n_we, 10);
      @(negedge tb_clk_baudrate);
      #2 reset = 1'b1;
      #1;
      chk("mid_rst_busy", int'(busy), 0);
      chk("mid_rst_we", int'(ram_we), 0);
      chk("mid_rst_bright", int'(brightness), 8'hFF);
      chk("mid_rst_addr", int'(ram_addr), 0);
      chk("mid_rst_data", int'(ram_data), 0);
      chk("mid_rst_err", int'(frame_error), 0);
      @(negedge tb_clk_baudrate);
      reset = 1'b0;
      settle(1);
      send_byte(8'h42, 0); send_byte(8'h10, 0); settle(2);
      chk("post_rst_bright", int'(brightness), 8'h10);

      // Randomized frames
      for (int f = 0; f < 24; f++) begin
         int kind;
         bit inv;
         kind = $urandom_range(0, 9);
         if (kind <= 4) begin
            send_byte(8'h4C, 0); send_byte(8'($urandom), 0);
            for (int i = 0; i < ROW_BYTES; i++) begin
               inv = ($urandom_range(0, 39) == 0);
               send_byte(8'($urandom), inv);
               if (inv) break;
            end
         end else if (kind <= 7) begin
            send_byte(8'h42, 0); send_byte(8'($urandom), 0);
         end else if (kind == 8) begin
            logic [7:0] j;
            j = 8'($urandom);
            if (j == 8'h4C || j == 8'h42) j = 8'h00;
            send_byte(j, 0);
         end else begin
            send_byte(8'h4C, 1);
         end
      end
      settle(4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
